booth_r4_seq_mult: RTL

BOOTH_R4_SEQ_MULT -- requirements
Module: booth_r4_seq_mult

---
 rtl/booth_r4_seq_mult.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/booth_r4_seq_mult.sv
// Sequential signed multiplier: radix-4 Booth recoding of b, one digit per clock,
// valid/ready handshakes on operands and product.
module booth_r4_seq_mult #(
  parameter int unsigned BITWIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BITWIDTH-1:0]   a,
  input  logic [BITWIDTH-1:0]   b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*BITWIDTH-1:0] product,
  output logic                  busy
);

  localparam int unsigned PW    = 2 * BITWIDTH;
  localparam int unsigned NDIG  = BITWIDTH / 2;
  localparam int unsigned CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int unsigned SH_W  = CNT_W + 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NDIG - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [BITWIDTH-1:0] a_q;
  logic [BITWIDTH-1:0] b_q;
  logic [PW-1:0]       acc_q;
  logic [CNT_W-1:0]    cnt_q;

  logic                accept_c;
  logic                step_c;
  logic [BITWIDTH:0]   b_ext_c;
  logic [SH_W-1:0]     shamt_c;
  logic [2:0]          triple_c;
  logic [PW-1:0]       a_ext_c;
  logic [PW-1:0]       mag_c;
  logic                neg_c;
  logic [PW-1:0]       pp_c;
  logic [PW-1:0]       corr_c;
  logic [PW-1:0]       acc_nxt_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath strobes
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    step_c   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept_c = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        step_c = 1'b1;
        if (cnt_q == LAST_DIGIT) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Booth digit selection and partial-product formation for the current digit
  always_comb begin
    b_ext_c  = {b_q, 1'b0};
    shamt_c  = {cnt_q, 1'b0};
    triple_c = 3'(b_ext_c >> shamt_c);
    a_ext_c  = {{BITWIDTH{a_q[BITWIDTH-1]}}, a_q};
    mag_c    = '0;
    neg_c    = 1'b0;
    unique case (triple_c)
      3'b001, 3'b010: mag_c = a_ext_c;
      3'b011:         mag_c = a_ext_c << 1;
      3'b100: begin
        mag_c = a_ext_c << 1;
        neg_c = 1'b1;
      end
      3'b101, 3'b110: begin
        mag_c = a_ext_c;
        neg_c = 1'b1;
      end
      default: begin
        mag_c = '0;
        neg_c = 1'b0;
      end
    endcase
    // Negative digits: ones' complement here, the +1 lands at bit 2i via corr_c
    pp_c      = (neg_c ? ~mag_c : mag_c) << shamt_c;
    corr_c    = neg_c ? (PW'(1) << shamt_c) : '0;
    acc_nxt_c = acc_q + pp_c + corr_c;
  end

  // Operand, accumulator and digit-counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (accept_c) begin
      a_q   <= a;
      b_q   <= b;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (step_c) begin
      acc_q <= acc_nxt_c;
      if (cnt_q != LAST_DIGIT) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Registered status outputs follow the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      busy      <= (state_d != IDLE);
    end
  end

  assign product = acc_q;

endmodule
